// File: rtl/linear_probe_store_pkg.sv
// -----------------------------------------------------------------------------
// linear_probe_store_pkg
// Shared encodings for the linear-probe key/value store: command and status
// codes, per-slot state, controller FSM states, the slot record and table
// geometry.
// -----------------------------------------------------------------------------
package linear_probe_store_pkg;

   localparam int unsigned NUM_SLOTS = 8;
   localparam int unsigned IDX_W     = 3;
   localparam int unsigned KEY_W     = 4;
   localparam int unsigned VAL_W     = 4;

   typedef enum logic [1:0] {
      CMD_LOOKUP = 2'd0,
      CMD_INSERT = 2'd1,
      CMD_DELETE = 2'd2,
      CMD_CLEAR  = 2'd3
   } cmd_e;

   typedef enum logic [1:0] {
      ST_OK        = 2'd0,
      ST_NOT_FOUND = 2'd1,
      ST_FULL      = 2'd2,
      ST_BUSY      = 2'd3
   } status_e;

   typedef enum logic [1:0] {
      SLOT_EMPTY     = 2'd0,
      SLOT_OCCUPIED  = 2'd1,
      SLOT_TOMBSTONE = 2'd2
   } slot_state_e;

   typedef enum logic [1:0] {
      FSM_IDLE  = 2'd0,
      FSM_PROBE = 2'd1,
      FSM_DONE  = 2'd2
   } fsm_state_e;

   typedef struct packed {
      slot_state_e      state;
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] val;
   } slot_t;

   // Probe sequence step; the index width makes 7 wrap to 0.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return idx + 1'b1;
   endfunction

endpackage

// File: rtl/linear_probe_store_slot_file.sv
// -----------------------------------------------------------------------------
// lps_slot_file
// Eight-entry slot storage for linear_probe_store.
//   clk, rst_n : clock, synchronous active-low reset (all slots EMPTY)
//   rd_idx     : combinational read port address
//   rd_slot    : slot record at rd_idx
//   we, wr_idx, wr_slot : single write port, applied on the rising edge
//   clr        : set every slot EMPTY on the rising edge (wins over we)
// -----------------------------------------------------------------------------
module lps_slot_file
   import linear_probe_store_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output slot_t            rd_slot,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  slot_t            wr_slot,
   input  logic             clr
);

   slot_t slots_q [NUM_SLOTS];
   slot_t slots_d [NUM_SLOTS];

   assign rd_slot = slots_q[rd_idx];

   always_comb begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         slots_d[i] = slots_q[i];
      end
      if (clr) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            slots_d[i] = '{state: SLOT_EMPTY, key: '0, val: '0};
         end
      end else if (we) begin
         slots_d[wr_idx] = wr_slot;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            slots_q[i] <= '{state: SLOT_EMPTY, key: '0, val: '0};
         end
      end else begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            slots_q[i] <= slots_d[i];
         end
      end
   end

endmodule

// File: rtl/linear_probe_store.sv
// -----------------------------------------------------------------------------
// linear_probe_store
// Open-addressing hash table (8 slots, linear probing, tombstone deletes).
//   clk, rst_n : clock, synchronous active-low reset
//   go         : level request; a command is accepted on its 0->1 edge in IDLE
//   cmd        : 0 LOOKUP, 1 INSERT, 2 DELETE, 3 CLEAR
//   hash       : home slot, supplied by the initiator
//   key, val   : operands
//   status     : 0 OK/FOUND, 1 NOT_FOUND, 2 FULL, 3 BUSY
//   out        : LOOKUP result value (0 for every other result)
// One slot is examined per PROBE cycle; the result is latched in DONE and
// held on status/out until the next command goes BUSY.
// -----------------------------------------------------------------------------
module linear_probe_store
   import linear_probe_store_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             go,
   input  logic [1:0]       cmd,
   input  logic [IDX_W-1:0] hash,
   input  logic [KEY_W-1:0] key,
   input  logic [VAL_W-1:0] val,
   output logic [1:0]       status,
   output logic [VAL_W-1:0] out
);

   fsm_state_e       state_q, state_d;
   logic             go_q, go_d;
   logic             armed_q, armed_d;
   cmd_e             cmd_q, cmd_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [VAL_W-1:0] val_q, val_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             ff_valid_q, ff_valid_d;
   logic [IDX_W-1:0] ff_idx_q, ff_idx_d;
   status_e          res_status_q, res_status_d;
   logic [VAL_W-1:0] res_out_q, res_out_d;
   status_e          status_q, status_d;
   logic [VAL_W-1:0] out_q, out_d;

   slot_t            rd_slot;
   logic             we;
   logic [IDX_W-1:0] wr_idx;
   slot_t            wr_slot;
   logic             clr;

   logic accept;
   logic hit, is_empty, is_tomb, last_probe, term;

   lps_slot_file u_slots (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_idx  (idx_q),
      .rd_slot (rd_slot),
      .we      (we),
      .wr_idx  (wr_idx),
      .wr_slot (wr_slot),
      .clr     (clr)
   );

   assign status = status_q;
   assign out    = out_q;

   always_comb begin
      state_d      = state_q;
      go_d         = go;
      // A go level held through reset release must fall once before it can
      // start a command.
      armed_d      = armed_q | ~go;
      cmd_d        = cmd_q;
      key_d        = key_q;
      val_d        = val_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      ff_valid_d   = ff_valid_q;
      ff_idx_d     = ff_idx_q;
      res_status_d = res_status_q;
      res_out_d    = res_out_q;
      status_d     = status_q;
      out_d        = out_q;
      we           = 1'b0;
      wr_idx       = idx_q;
      wr_slot      = '{state: SLOT_OCCUPIED, key: key_q, val: val_q};
      clr          = 1'b0;
      term         = 1'b0;

      accept     = go & ~go_q & armed_q & (state_q == FSM_IDLE);
      hit        = (rd_slot.state == SLOT_OCCUPIED) && (rd_slot.key == key_q);
      is_empty   = (rd_slot.state == SLOT_EMPTY);
      is_tomb    = (rd_slot.state == SLOT_TOMBSTONE);
      last_probe = (cnt_q == 3'd7);

      case (state_q)
         FSM_IDLE: begin
            if (accept) begin
               state_d    = FSM_PROBE;
               cmd_d      = cmd_e'(cmd);
               key_d      = key;
               val_d      = val;
               idx_d      = hash;
               cnt_d      = '0;
               ff_valid_d = 1'b0;
            end
         end

         FSM_PROBE: begin
            status_d     = ST_BUSY;
            res_status_d = ST_OK;
            res_out_d    = '0;
            case (cmd_q)
               CMD_LOOKUP: begin
                  if (hit) begin
                     term      = 1'b1;
                     res_out_d = rd_slot.val;
                  end else if (is_empty || last_probe) begin
                     term         = 1'b1;
                     res_status_d = ST_NOT_FOUND;
                  end
               end

               CMD_INSERT: begin
                  if (!ff_valid_q && (is_empty || is_tomb)) begin
                     ff_valid_d = 1'b1;
                     ff_idx_d   = idx_q;
                  end
                  if (hit) begin
                     term = 1'b1;
                     we   = 1'b1;
                  end else if (is_empty || (last_probe && (ff_valid_q || is_tomb))) begin
                     // The earliest reusable slot wins; when none was seen
                     // before this probe, the current slot is that slot.
                     term   = 1'b1;
                     we     = 1'b1;
                     wr_idx = ff_valid_q ? ff_idx_q : idx_q;
                  end else if (last_probe) begin
                     term         = 1'b1;
                     res_status_d = ST_FULL;
                  end
               end

               CMD_DELETE: begin
                  if (hit) begin
                     term    = 1'b1;
                     we      = 1'b1;
                     wr_slot = '{state: SLOT_TOMBSTONE, key: rd_slot.key, val: rd_slot.val};
                  end else if (is_empty || last_probe) begin
                     term         = 1'b1;
                     res_status_d = ST_NOT_FOUND;
                  end
               end

               default: begin
                  term = 1'b1;
                  clr  = 1'b1;
               end
            endcase

            if (term) begin
               state_d = FSM_DONE;
            end else begin
               idx_d = next_idx(idx_q);
               cnt_d = cnt_q + 3'd1;
            end
         end

         FSM_DONE: begin
            status_d   = res_status_q;
            out_d      = res_out_q;
            ff_valid_d = 1'b0;
            state_d    = FSM_IDLE;
         end

         default: begin
            state_d = FSM_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= FSM_IDLE;
         go_q         <= 1'b0;
         armed_q      <= 1'b0;
         cmd_q        <= CMD_LOOKUP;
         key_q        <= '0;
         val_q        <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
         ff_valid_q   <= 1'b0;
         ff_idx_q     <= '0;
         res_status_q <= ST_OK;
         res_out_q    <= '0;
         status_q     <= ST_OK;
         out_q        <= '0;
      end else begin
         state_q      <= state_d;
         go_q         <= go_d;
         armed_q      <= armed_d;
         cmd_q        <= cmd_d;
         key_q        <= key_d;
         val_q        <= val_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         ff_valid_q   <= ff_valid_d;
         ff_idx_q     <= ff_idx_d;
         res_status_q <= res_status_d;
         res_out_q    <= res_out_d;
         status_q     <= status_d;
         out_q        <= out_d;
      end
   end

endmodule

// File: tb/tb_linear_probe_store.sv
// -----------------------------------------------------------------------------
// tb_linear_probe_store
// Directed bench for linear_probe_store. Each vector carries a hand-computed
// status, out and latency (cycles from the acceptance edge to the first
// non-BUSY status, i.e. probes + 1).
// -----------------------------------------------------------------------------
module tb_linear_probe_store;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       go = 1'b0;
   logic [1:0] cmd = 2'd0;
   logic [2:0] hash = 3'd0;
   logic [3:0] key = 4'd0;
   logic [3:0] val = 4'd0;
   logic [1:0] status;
   logic [3:0] out;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0] c;
      logic [3:0] k;
      logic [3:0] v;
      logic [2:0] h;
      logic [1:0] est;
      logic [3:0] eout;
      int         elat;
   } vec_t;

   localparam logic [1:0] LKP = 2'd0, INS = 2'd1, DEL = 2'd2, CLR = 2'd3;

   linear_probe_store dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .go     (go),
      .cmd    (cmd),
      .hash   (hash),
      .key    (key),
      .val    (val),
      .status (status),
      .out    (out)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [1:0] c, input logic [3:0] k, input logic [3:0] v,
                               input logic [2:0] h, input logic [1:0] est, input logic [3:0] eout,
                               input int elat);
      vec_t t;
      t.c = c; t.k = k; t.v = v; t.h = h; t.est = est; t.eout = eout; t.elat = elat;
      return t;
   endfunction

   // Drive one command; lat = 0 if no result appears within 20 cycles.
   task automatic issue(input vec_t t, output logic [1:0] st, output logic [3:0] o, output int lat);
      @(negedge clk);
      cmd = t.c; key = t.k; val = t.v; hash = t.h; go = 1'b1;
      @(posedge clk);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (status !== 2'd3) begin
            lat = i;
            break;
         end
      end
      st = status;
      o  = out;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; go = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_checks++;
      if (status !== 2'd0 || out !== 4'd0) begin
         n_fail++;
         $display("FAIL reset: status=%0d out=%0d, required status=0 out=0", status, out);
      end
   endtask

   task automatic test_go_high_at_reset();
      logic bad;
      bad = 1'b0;
      @(negedge clk);
      rst_n = 1'b0; go = 1'b1; cmd = LKP; key = 4'd0; hash = 3'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (status !== 2'd0) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL go_high_at_reset: status=%0d, required 0 with no command accepted", status);
      end
      @(negedge clk);
      go = 1'b0;
      @(posedge clk);
   endtask

   task automatic test_basic();
      vec_t vq[$];
      logic [1:0] st; logic [3:0] o; int lat;
      vq.push_back(mk(LKP, 4'd5, 4'd0, 3'd2, 2'd1, 4'd0, 2));
      vq.push_back(mk(INS, 4'd5, 4'd9, 3'd2, 2'd0, 4'd0, 2));
      vq.push_back(mk(LKP, 4'd5, 4'd0, 3'd2, 2'd0, 4'd9, 2));
      vq.push_back(mk(INS, 4'd5, 4'd4, 3'd2, 2'd0, 4'd0, 2));
      vq.push_back(mk(LKP, 4'd5, 4'd0, 3'd2, 2'd0, 4'd4, 2));
      foreach (vq[i]) begin
         issue(vq[i], st, o, lat);
         n_checks++;
         if (st !== vq[i].est || o !== vq[i].eout || lat != vq[i].elat) begin
            n_fail++;
            $display("FAIL basic[%0d]: status=%0d out=%0d lat=%0d, required status=%0d out=%0d lat=%0d",
                     i, st, o, lat, vq[i].est, vq[i].eout, vq[i].elat);
         end
      end
   endtask

   task automatic test_wrap();
      vec_t vq[$];
      logic [1:0] st; logic [3:0] o; int lat;
      vq.push_back(mk(INS, 4'd1, 4'd3, 3'd7, 2'd0, 4'd0, 2));
      vq.push_back(mk(INS, 4'd2, 4'd6, 3'd7, 2'd0, 4'd0, 3));
      vq.push_back(mk(LKP, 4'd2, 4'd0, 3'd7, 2'd0, 4'd6, 3));
      vq.push_back(mk(LKP, 4'd2, 4'd0, 3'd0, 2'd0, 4'd6, 2));
      foreach (vq[i]) begin
         issue(vq[i], st, o, lat);
         n_checks++;
         if (st !== vq[i].est || o !== vq[i].eout || lat != vq[i].elat) begin
            n_fail++;
            $display("FAIL wrap[%0d]: status=%0d out=%0d lat=%0d, required status=%0d out=%0d lat=%0d",
                     i, st, o, lat, vq[i].est, vq[i].eout, vq[i].elat);
         end
      end
   endtask

   task automatic test_full();
      vec_t vq[$];
      logic [1:0] st; logic [3:0] o; int lat;
      vq.push_back(mk(CLR, 4'd0, 4'd0, 3'd0, 2'd0, 4'd0, 2));
      for (int k = 0; k < 8; k++) begin
         vq.push_back(mk(INS, 4'(k), 4'(k + 1), 3'(k), 2'd0, 4'd0, 2));
      end
      vq.push_back(mk(INS, 4'd8, 4'd9,  3'd0, 2'd2, 4'd0, 9));
      vq.push_back(mk(INS, 4'd3, 4'd15, 3'd0, 2'd0, 4'd0, 5));
      vq.push_back(mk(LKP, 4'd3, 4'd0,  3'd0, 2'd0, 4'd15, 5));
      vq.push_back(mk(LKP, 4'd9, 4'd0,  3'd5, 2'd1, 4'd0, 9));
      vq.push_back(mk(DEL, 4'd9, 4'd0,  3'd0, 2'd1, 4'd0, 9));
      vq.push_back(mk(DEL, 4'd5, 4'd0,  3'd5, 2'd0, 4'd0, 2));
      vq.push_back(mk(INS, 4'd8, 4'd9,  3'd0, 2'd0, 4'd0, 9));
      vq.push_back(mk(LKP, 4'd8, 4'd0,  3'd5, 2'd0, 4'd9, 2));
      foreach (vq[i]) begin
         issue(vq[i], st, o, lat);
         n_checks++;
         if (st !== vq[i].est || o !== vq[i].eout || lat != vq[i].elat) begin
            n_fail++;
            $display("FAIL full[%0d]: status=%0d out=%0d lat=%0d, required status=%0d out=%0d lat=%0d",
                     i, st, o, lat, vq[i].est, vq[i].eout, vq[i].elat);
         end
      end
   endtask

   task automatic test_tombstone();
      vec_t vq[$];
      logic [1:0] st; logic [3:0] o; int lat;
      vq.push_back(mk(CLR, 4'd0,  4'd0, 3'd0, 2'd0, 4'd0, 2));
      vq.push_back(mk(INS, 4'd10, 4'd1, 3'd3, 2'd0, 4'd0, 2));
      vq.push_back(mk(INS, 4'd11, 4'd2, 3'd3, 2'd0, 4'd0, 3));
      vq.push_back(mk(DEL, 4'd10, 4'd0, 3'd3, 2'd0, 4'd0, 2));
      vq.push_back(mk(LKP, 4'd11, 4'd0, 3'd3, 2'd0, 4'd2, 3));
      vq.push_back(mk(INS, 4'd12, 4'd3, 3'd3, 2'd0, 4'd0, 4));
      vq.push_back(mk(LKP, 4'd12, 4'd0, 3'd3, 2'd0, 4'd3, 2));
      vq.push_back(mk(LKP, 4'd11, 4'd0, 3'd3, 2'd0, 4'd2, 3));
      vq.push_back(mk(CLR, 4'd0,  4'd0, 3'd0, 2'd0, 4'd0, 2));
      vq.push_back(mk(LKP, 4'd11, 4'd0, 3'd3, 2'd1, 4'd0, 2));
      foreach (vq[i]) begin
         issue(vq[i], st, o, lat);
         n_checks++;
         if (st !== vq[i].est || o !== vq[i].eout || lat != vq[i].elat) begin
            n_fail++;
            $display("FAIL tombstone[%0d]: status=%0d out=%0d lat=%0d, required status=%0d out=%0d lat=%0d",
                     i, st, o, lat, vq[i].est, vq[i].eout, vq[i].elat);
         end
      end
   endtask

   task automatic test_hold_go();
      logic [1:0] st; logic [3:0] o; int lat;
      int runs;
      logic prev_busy;
      issue(mk(INS, 4'd7, 4'd1, 3'd1, 2'd0, 4'd0, 2), st, o, lat);
      n_checks++;
      if (st !== 2'd0 || lat != 2) begin
         n_fail++;
         $display("FAIL hold_setup: status=%0d lat=%0d, required status=0 lat=2", st, lat);
      end
      runs = 0; prev_busy = 1'b0;
      @(negedge clk);
      cmd = DEL; key = 4'd7; hash = 3'd1; go = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (status === 2'd3 && !prev_busy) runs++;
         prev_busy = (status === 2'd3);
      end
      n_checks++;
      if (runs != 1 || status !== 2'd0 || out !== 4'd0) begin
         n_fail++;
         $display("FAIL hold_go: busy_runs=%0d status=%0d out=%0d, required busy_runs=1 status=0 out=0",
                  runs, status, out);
      end
      @(negedge clk);
      go = 1'b0;
      issue(mk(LKP, 4'd7, 4'd0, 3'd1, 2'd1, 4'd0, 3), st, o, lat);
      n_checks++;
      if (st !== 2'd1 || o !== 4'd0 || lat != 3) begin
         n_fail++;
         $display("FAIL hold_lookup: status=%0d out=%0d lat=%0d, required status=1 out=0 lat=3", st, o, lat);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] st; logic [3:0] o; int lat;
      issue(mk(INS, 4'd4, 4'd4, 3'd4, 2'd0, 4'd0, 2), st, o, lat);
      issue(mk(LKP, 4'd4, 4'd0, 3'd4, 2'd0, 4'd4, 2), st, o, lat);
      n_checks++;
      if (st !== 2'd0 || o !== 4'd4 || lat != 2) begin
         n_fail++;
         $display("FAIL rmid_setup: status=%0d out=%0d lat=%0d, required status=0 out=4 lat=2", st, o, lat);
      end
      @(negedge clk);
      cmd = INS; key = 4'd6; val = 4'd6; hash = 3'd4; go = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      n_checks++;
      if (status !== 2'd3) begin
         n_fail++;
         $display("FAIL rmid_busy: status=%0d, required 3", status);
      end
      @(negedge clk);
      rst_n = 1'b0; go = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_checks++;
      if (status !== 2'd0 || out !== 4'd0) begin
         n_fail++;
         $display("FAIL rmid_reset: status=%0d out=%0d, required status=0 out=0", status, out);
      end
      issue(mk(LKP, 4'd4, 4'd0, 3'd4, 2'd1, 4'd0, 2), st, o, lat);
      n_checks++;
      if (st !== 2'd1 || o !== 4'd0 || lat != 2) begin
         n_fail++;
         $display("FAIL rmid_lookup4: status=%0d out=%0d lat=%0d, required status=1 out=0 lat=2", st, o, lat);
      end
      issue(mk(LKP, 4'd6, 4'd0, 3'd5, 2'd1, 4'd0, 2), st, o, lat);
      n_checks++;
      if (st !== 2'd1 || o !== 4'd0 || lat != 2) begin
         n_fail++;
         $display("FAIL rmid_lookup6: status=%0d out=%0d lat=%0d, required status=1 out=0 lat=2", st, o, lat);
      end
   endtask

   initial begin
      test_reset();
      test_go_high_at_reset();
      test_basic();
      test_wrap();
      test_full();
      test_tombstone();
      test_hold_go();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
